alu_mac_sequencer: RTL
======================

# alu_mac_sequencer

Initiator-side controller for the team's combinational ALU. It computes one neuron pre-activation, y = bias ± Σ xᵢ·wᵢ, by taking (x, w) pairs from an input stream and issuing a multiply followed by an accumulate on the ALU's `Operand_1`/`Operand_2`/`op_select`/`enable_ALU` interface. It returns the 16-bit result on a valid/ready output. It sits between the layer memory/streamer and a single ALU instance, which is instantiated by the parent.

## Interface
- `DATA_W`, 16: operand and result width. Must match the ALU.
- `LEN_W`, 8: width of the term-count input.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a dot product; sampled only in IDLE.
- `len`  in  LEN_W  number of (x, w) terms; captured on an accepted `start`.
- `bias`  in  DATA_W  initial accumulator value; captured on an accepted `start`.
- `sub_mode`  in  1  captured on an accepted `start`. 0: acc + product. 1: acc − product.
- `in_valid`  in  1  an (x, w) pair is present.
- `in_ready`  out  1  the sequencer accepts a pair this cycle.
- `in_x`  in  DATA_W  activation term.
- `in_w`  in  DATA_W  weight term.
- `alu_enable`  out  1  drives the ALU's `enable_ALU`.
- `alu_op_select`  out  2  drives the ALU's `op_select`.
- `alu_operand_1`  out  DATA_W  drives the ALU's `Operand_1`.
- `alu_operand_2`  out  DATA_W  drives the ALU's `Operand_2`.
- `alu_result`  in  DATA_W  the ALU's `result`, combinational from the outputs above.
- `out_valid`  out  1  the final accumulator is presented.
- `out_ready`  in  1  the consumer takes the result.
- `out_data`  out  DATA_W  the final accumulator.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States and transitions:
  - IDLE:
    - `start`=1 captures `len`, `bias` and `sub_mode`, sets acc←bias and cnt←0.
    - Next state is DONE if `len`=0, otherwise FETCH.
  - FETCH:
    - `in_ready`=1.
    - On `in_valid`, register x and w, then go to MUL.
  - MUL:
    - Drive `alu_enable`=1, `alu_op_select`=2'b10, operand_1=x, operand_2=w.
    - Register `alu_result` as prod, then go to ACC.
  - ACC:
    - Drive `alu_enable`=1, operand_1=acc, operand_2=prod.
    - `alu_op_select` is 2'b00 when `sub_mode`=0 and 2'b01 when `sub_mode`=1.
    - acc←`alu_result`, cnt←cnt+1.
    - Next state is DONE if cnt+1 = len, otherwise FETCH.
  - DONE:
    - `out_valid`=1, `out_data`=acc.
    - On `out_ready`, go to IDLE.
- Outside MUL and ACC: `alu_enable`=0, `alu_op_select`=2'b00, and both operands are 0.
- The sequencer does no arithmetic of its own. The add/sub wrap modulo 2^DATA_W and the product format are defined entirely by the ALU.
- `start` outside IDLE is ignored, including `start` in the same cycle as the DONE handshake.
- `in_ready` is 0 outside FETCH. Pairs offered at other times are not consumed.
- `len`=255 is legal, and the cnt width covers it without wrap.

## Timing
- Reset values: state IDLE, acc=0, prod=0, cnt=0, x=w=0.
- Output reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, `alu_enable`=0, `alu_op_select`=0, operands 0.
- Reset asserted in any state aborts the operation immediately. `out_valid` must not assert for the aborted job.
- Per term: 3 cycles minimum (FETCH, MUL, ACC), plus any cycles FETCH waits for `in_valid`.
- Latency from `start` to `out_valid` with an always-valid input is 1 + 3·len cycles. With `len`=0 it is 1 cycle.
- `out_valid` and `out_data` are stable until `out_ready`. Backpressure never stalls the ALU, because the ALU is idle in DONE.
- All outputs are registered state decodes or registered values. No combinational path runs from `in_*`/`out_ready` to `alu_*`.

## Structure
- Shared package:
  - ALU op encodings: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_MUL=2'b10.
  - Default data width of 16.
  - The FSM state encoding: IDLE, FETCH, MUL, ACC, DONE.
- No sub-module. The ALU lives in the parent so the datapath can share it. The counter and FSM are inline.

## Test plan
The bench uses an ALU stub. Op 00 gives a+b mod 2^16, op 01 gives a−b mod 2^16, op 10 gives the low 16 bits of a·b, and the output is 0 when enable is 0. Each scenario below is stimulus -> required response.

- Basic accumulate: bias=5, `sub_mode`=0, len=2, pairs (2,4) and (3,1) with `in_valid` held high -> `out_data`=16 at cycle 7 after `start`. `alu_op_select` sequence is 10, 00, 10, 00.
- Subtract mode: bias=100, `sub_mode`=1, len=1, pair (6,7) -> `out_data`=58.
- Zero length and wrap:
  - len=0, bias=0x1234 -> `out_valid` 1 cycle after `start` with `out_data`=0x1234, and no ALU enable.
  - bias=0xFFFF, len=1, pair (1,1) -> `out_data`=0x0000.
- Handshakes:
  - `in_valid` gaps of 3 cycles between pairs stretch latency by exactly 3 cycles per gap with the same result.
  - `out_ready` held low 5 cycles keeps `out_valid`/`out_data` stable.
  - `start` pulsed during ACC is ignored.
- Reset mid-operation: assert `rst` during MUL of term 2 of 3 -> all outputs at reset values asynchronously and no `out_valid`. A following job with bias=1 and pair (1,1) returns 2.

Source files
------------

// File: rtl/alu_mac_sequencer_pkg.sv
// alu_mac_sequencer_pkg: ALU op encodings, default width and FSM state encoding
package alu_mac_sequencer_pkg;
   localparam int DATA_W_DEF = 16;
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_MUL = 2'b10;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_MUL   = 3'd2;
   localparam logic [2:0] ST_ACC   = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
endpackage

// File: rtl/alu_mac_sequencer.sv
// alu_mac_sequencer: drives a shared ALU through multiply/accumulate steps to compute bias +/- sum(x*w)
module alu_mac_sequencer
   import alu_mac_sequencer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic [DATA_W-1:0] bias,
   input  logic              sub_mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_x,
   input  logic [DATA_W-1:0] in_w,
   output logic              alu_enable,
   output logic [1:0]        alu_op_select,
   output logic [DATA_W-1:0] alu_operand_1,
   output logic [DATA_W-1:0] alu_operand_2,
   input  logic [DATA_W-1:0] alu_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy
);
   logic [2:0]        state;
   logic [DATA_W-1:0] acc, prod, x, w;
   logic [LEN_W-1:0]  cnt, len_q;
   logic              sub_q;
   logic [LEN_W:0]    cnt_inc;
   assign cnt_inc = {1'b0, cnt} + 1'b1;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         acc   <= '0;
         prod  <= '0;
         cnt   <= '0;
         x     <= '0;
         w     <= '0;
         len_q <= '0;
         sub_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               len_q <= len;
               sub_q <= sub_mode;
               acc   <= bias;
               cnt   <= '0;
               state <= (len == '0) ? ST_DONE : ST_FETCH;
            end
            ST_FETCH: if (in_valid) begin
               x     <= in_x;
               w     <= in_w;
               state <= ST_MUL;
            end
            ST_MUL: begin
               prod  <= alu_result;
               state <= ST_ACC;
            end
            ST_ACC: begin
               acc   <= alu_result;
               cnt   <= cnt_inc[LEN_W-1:0];
               state <= (cnt_inc == {1'b0, len_q}) ? ST_DONE : ST_FETCH;
            end
            ST_DONE: if (out_ready) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end
   always_comb begin
      in_ready      = state == ST_FETCH;
      busy          = state != ST_IDLE;
      out_valid     = state == ST_DONE;
      out_data      = out_valid ? acc : '0;
      alu_enable    = (state == ST_MUL) || (state == ST_ACC);
      alu_op_select = (state == ST_MUL) ? ALU_MUL : (state == ST_ACC && sub_q) ? ALU_SUB : ALU_ADD;
      alu_operand_1 = (state == ST_MUL) ? x : (state == ST_ACC) ? acc : '0;
      alu_operand_2 = (state == ST_MUL) ? w : (state == ST_ACC) ? prod : '0;
   end
endmodule
